// File: rtl/ttt_game_core_if.sv
// Bus bundle between the keypad/display side and the tic-tac-toe engine.
interface ttt_game_core_if #(
  parameter int N  = 3,
  parameter int KW = 5
);
  localparam int CELLS = N * N;

  logic                 start;
  logic                 key_valid;
  logic [KW-1:0]        key_code;
  logic [KW-1:0]        rd_addr;
  logic [1:0]           rd_val;
  logic [2*CELLS-1:0]   board;
  logic                 turn_o;
  logic                 busy;
  logic                 move_err;
  logic                 game_over;
  logic [1:0]           winner;
  logic [3:0]           win_line;
  logic [KW-1:0]        move_count;

  // Keypad/display side drives requests and observes game state.
  modport master (
    output start, key_valid, key_code, rd_addr,
    input  rd_val, board, turn_o, busy, move_err, game_over, winner, win_line, move_count
  );

  // Engine side.
  modport slave (
    input  start, key_valid, key_code, rd_addr,
    output rd_val, board, turn_o, busy, move_err, game_over, winner, win_line, move_count
  );
endinterface

// File: rtl/ttt_game_core.sv
// N x N tic-tac-toe engine: validates moves, alternates X/O, and scans one
// line per cycle for a win by the player who just moved.
module ttt_game_core #(
  parameter int N  = 3,
  parameter int KW = 5
) (
  input logic           clk,
  input logic           rst,
  ttt_game_core_if.slave bus
);
  localparam int CELLS = N * N;
  localparam int NL    = 2 * N + 2;
  localparam logic [3:0] LAST_LINE = 4'(NL - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_DONE} state_t;

  state_t        state_q;
  logic [1:0]    cell_q [CELLS];
  logic          turn_q;
  logic [1:0]    winner_q;
  logic [3:0]    line_q;
  logic [3:0]    win_line_q;
  logic [KW-1:0] count_q;
  logic          move_err_q;
  logic [1:0]    rd_val_q;

  logic [1:0]    mover_d;
  logic [NL-1:0] line_hit_d;
  logic          hit_d;
  logic          key_range_ok_d;
  logic          key_occupied_d;
  logic [KW-1:0] key_idx_d;
  logic [1:0]    rd_cell_d;

  // Cell code of the player whose move is being checked.
  assign mover_d = turn_q ? 2'd2 : 2'd1;

  // Every line is compared in parallel; CHECK picks one per cycle via line_q.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_line
      logic [N-1:0] match;
      for (gk = 0; gk < N; gk++) begin : g_pos
        localparam int CELL = (gi < N)     ? gi * N + gk :
                              (gi < 2 * N) ? (gi - N) + gk * N :
                              (gi == 2 * N) ? gk * N + gk :
                                              gk * N + (N - 1 - gk);
        assign match[gk] = (cell_q[CELL] == mover_d);
      end
      assign line_hit_d[gi] = &match;
    end

    for (gi = 0; gi < CELLS; gi++) begin : g_board
      assign bus.board[2*gi +: 2] = cell_q[gi];
    end
  endgenerate

  // Select the line under test and decode the incoming key / read address.
  always_comb begin
    hit_d          = 1'b0;
    key_occupied_d = 1'b0;
    rd_cell_d      = 2'd0;
    key_range_ok_d = (bus.key_code != '0) && (bus.key_code <= KW'(CELLS));
    key_idx_d      = bus.key_code - KW'(1);
    for (int l = 0; l < NL; l++) begin
      if (line_q == 4'(l)) hit_d = line_hit_d[l];
    end
    for (int c = 0; c < CELLS; c++) begin
      if (key_idx_d == KW'(c) && cell_q[c] != 2'd0) key_occupied_d = 1'b1;
      if (bus.rd_addr == KW'(c)) rd_cell_d = cell_q[c];
    end
  end

  // Game FSM: start has priority over everything but reset, and aborts any scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int c = 0; c < CELLS; c++) cell_q[c] <= 2'd0;
      turn_q     <= 1'b0;
      winner_q   <= 2'b00;
      win_line_q <= 4'd0;
      line_q     <= 4'd0;
      count_q    <= '0;
      move_err_q <= 1'b0;
      rd_val_q   <= 2'd0;
    end else begin
      move_err_q <= 1'b0;
      rd_val_q   <= rd_cell_d;
      if (bus.start) begin
        for (int c = 0; c < CELLS; c++) cell_q[c] <= 2'd0;
        turn_q     <= 1'b0;
        winner_q   <= 2'b00;
        win_line_q <= 4'd0;
        line_q     <= 4'd0;
        count_q    <= '0;
        state_q    <= S_PLAY;
      end else begin
        case (state_q)
          S_PLAY: begin
            if (bus.key_valid) begin
              if (!key_range_ok_d || key_occupied_d) begin
                move_err_q <= 1'b1;
              end else begin
                for (int c = 0; c < CELLS; c++) begin
                  if (key_idx_d == KW'(c)) cell_q[c] <= mover_d;
                end
                count_q <= count_q + KW'(1);
                line_q  <= 4'd0;
                state_q <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (hit_d) begin
              winner_q   <= mover_d;
              win_line_q <= line_q;
              state_q    <= S_DONE;
            end else if (line_q != LAST_LINE) begin
              line_q <= line_q + 4'd1;
            end else if (count_q == KW'(CELLS)) begin
              winner_q <= 2'b11;
              state_q  <= S_DONE;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= S_PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_val     = rd_val_q;
  assign bus.turn_o     = turn_q;
  assign bus.busy       = (state_q == S_CHECK);
  assign bus.move_err   = move_err_q;
  assign bus.game_over  = (state_q == S_DONE);
  assign bus.winner     = winner_q;
  assign bus.win_line   = win_line_q;
  assign bus.move_count = count_q;
endmodule
